// File: rtl/obi_port_arbiter.sv
// Shares one single-port OBI memory between the instruction and data ports:
// round-robin issue with a held winner until handshake, in-order response routing by source FIFO.
module obi_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [MAX_OUTSTANDING-1:0] src_fifo;
  logic                       last_grant;
  logic                       lock;
  logic                       locked_src;

  logic winner;
  logic winner_req;
  logic full;
  logic empty;
  logic handshake;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Winner selection: a stalled request keeps the bus; otherwise alternate on ties.
  always_comb begin
    winner = SRC_INSTR;
    if (lock) begin
      winner = locked_src;
    end else if (instr_req_i && data_req_i) begin
      winner = ~last_grant;
    end else if (data_req_i) begin
      winner = SRC_DATA;
    end
  end

  assign winner_req = (winner == SRC_DATA) ? data_req_i : instr_req_i;
  assign full       = (count >= CW'(MAX_OUTSTANDING));
  assign empty      = (count == '0);
  assign mem_req_o  = rst_ni & winner_req & ~full;
  assign handshake  = mem_req_o & mem_gnt_i;
  assign pop        = rst_ni & mem_rvalid_i & ~empty;

  // Issue mux; instruction fetches are full-word reads.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (winner == SRC_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = 4'hF;
      end
    end
  end

  assign instr_gnt_o    = handshake & (winner == SRC_INSTR);
  assign data_gnt_o     = handshake & (winner == SRC_DATA);
  assign instr_rvalid_o = pop & (src_fifo[rd_ptr] == SRC_INSTR);
  assign data_rvalid_o  = pop & (src_fifo[rd_ptr] == SRC_DATA);
  assign instr_rdata_o  = rst_ni ? mem_rdata_i : '0;
  assign data_rdata_o   = rst_ni ? mem_rdata_i : '0;
  assign err_o          = rst_ni & mem_rvalid_i & empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      src_fifo   <= '0;
      last_grant <= SRC_DATA;
      lock       <= 1'b0;
      locked_src <= SRC_INSTR;
    end else begin
      if (handshake) begin
        src_fifo[wr_ptr] <= winner;
        wr_ptr           <= ptr_inc(wr_ptr);
        last_grant       <= winner;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (handshake && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !handshake) begin
        count <= count - CW'(1);
      end
      // Hold the stalled winner so the memory side stays stable until granted.
      if (handshake) begin
        lock <= 1'b0;
      end else if (mem_req_o) begin
        lock       <= 1'b1;
        locked_src <= winner;
      end
    end
  end

  count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= CW'(MAX_OUTSTANDING));

endmodule
